tile_board_engine: RTL

//  2048 game-state engine. Holds the 4x4 board of tile exponents and executes

---
 rtl/tile_board_engine.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tile_board_engine.sv
// tile_board_engine: 2048 game-state engine.
// Holds the 4x4 board of tile exponents, executes slide/merge moves one line
// per cycle into a shadow board, then commits shadow plus a spawned tile in a
// single cycle so the renderers never see a half-finished move.
// Optional build macro: SPAWN_FOUR_EN
// - Defined: a spawn writes 2 (tile 4) when lfsr[6:4] == 3'b000.
// - Undefined: every spawn writes 1.
module tile_board_engine #(
  parameter int          CELL_W    = 4,
  parameter int unsigned WIN_EXP   = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iNew_game,
  input  logic                 iMove_valid,
  input  logic [1:0]           iMove_dir,
  input  logic                 iWr_en,
  input  logic [3:0]           iWr_idx,
  input  logic [CELL_W-1:0]    iWr_val,
  output logic [16*CELL_W-1:0] oGrid,
  output logic                 oReady,
  output logic                 oDone,
  output logic                 oMoved,
  output logic                 oGame_over,
  output logic                 oWin
);

  typedef logic [CELL_W-1:0]        cell_t;
  typedef logic [15:0][CELL_W-1:0]  board_t;
  typedef logic [3:0][CELL_W-1:0]   line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT0,
    ST_INIT1,
    ST_SLIDE,
    ST_SPAWN,
    ST_CHECK
  } state_t;

  state_t      state_reg;
  logic [1:0]  line_reg;
  logic [1:0]  dir_reg;
  board_t      grid_reg;
  board_t      shadow_reg;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic        ready_reg;
  logic        done_reg;
  logic        moved_reg;
  logic        over_reg;
  logic        win_reg;

  // Cell index of position p (0 = lead end) on line k for a move direction.
  function automatic logic [3:0] cell_idx(input logic [1:0] dir,
                                          input logic [1:0] k,
                                          input logic [1:0] p);
    logic [1:0] x;
    logic [1:0] y;
    x = p;
    y = k;
    case (dir)
      2'd0:    begin x = p;  y = k;  end
      2'd1:    begin x = ~p; y = k;  end
      2'd2:    begin x = k;  y = p;  end
      default: begin x = k;  y = ~p; end
    endcase
    return {y, x};
  endfunction

  // Merge result saturates at the largest representable exponent.
  function automatic cell_t sat_inc(input cell_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Compress toward the lead end, then merge equal pairs starting at the lead
  // end; a merged tile is skipped so it cannot merge a second time.
  function automatic line_t slide_line(input line_t in);
    logic [7:0][CELL_W-1:0] c;
    logic [2:0]             cnt;
    logic [2:0]             o;
    logic                   skip;
    line_t                  res;
    c    = '0;
    cnt  = '0;
    o    = '0;
    skip = 1'b0;
    res  = '0;
    for (logic [2:0] i = 3'd0; i < 3'd4; i = i + 3'd1) begin
      if (in[i[1:0]] != '0) begin
        c[cnt] = in[i[1:0]];
        cnt    = cnt + 3'd1;
      end
    end
    for (logic [2:0] i = 3'd0; i < 3'd4; i = i + 3'd1) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != '0) begin
        if (c[i + 3'd1] == c[i]) begin
          res[o[1:0]] = sat_inc(c[i]);
          skip        = 1'b1;
        end else begin
          res[o[1:0]] = c[i];
        end
        o = o + 3'd1;
      end
    end
    return res;
  endfunction

  // Line currently being processed, gathered from the committed board.
  logic [3:0] line_idx [4];
  line_t      line_in;
  line_t      line_out;

  for (genvar gi = 0; gi < 4; gi++) begin : g_line
    assign line_idx[gi] = cell_idx(dir_reg, line_reg, 2'(gi));
    assign line_in[gi]  = grid_reg[line_idx[gi]];
  end

  assign line_out = slide_line(line_in);

  // Per-cell flags for game-over and win detection on the committed board.
  logic [15:0] cell_zero;
  logic [15:0] cell_win;
  logic [15:0] pair_h;
  logic [15:0] pair_v;
  logic        board_over;

  for (genvar gi = 0; gi < 16; gi++) begin : g_cell
    assign cell_zero[gi] = (grid_reg[gi] == '0);
    assign cell_win[gi]  = (32'(grid_reg[gi]) >= WIN_EXP);
    if ((gi % 4) < 3) begin : g_h
      assign pair_h[gi] = (grid_reg[gi] == grid_reg[gi+1]);
    end else begin : g_hn
      assign pair_h[gi] = 1'b0;
    end
    if (gi < 12) begin : g_v
      assign pair_v[gi] = (grid_reg[gi] == grid_reg[gi+4]);
    end else begin : g_vn
      assign pair_v[gi] = 1'b0;
    end
  end

  assign board_over = ~(|cell_zero) & ~(|pair_h) & ~(|pair_v);

  board_t slide_board;
  board_t spawn_src;
  board_t spawn_board;
  logic   spawn_hit;
  logic [3:0] spawn_idx;
  logic [3:0] probe;
  cell_t  spawn_val;
  logic   board_moved;

  assign board_moved = (shadow_reg != grid_reg);

  // Shadow board with the current line replaced by its slid version.
  always_comb begin
    slide_board = shadow_reg;
    for (logic [2:0] p = 3'd0; p < 3'd4; p = p + 3'd1) begin
      slide_board[line_idx[p[1:0]]] = line_out[p[1:0]];
    end
  end

  // First empty cell scanning upward (mod 16) from the LFSR low nibble.
  always_comb begin
    spawn_src   = (state_reg == ST_SPAWN) ? shadow_reg : grid_reg;
    spawn_hit   = 1'b0;
    spawn_idx   = '0;
    probe       = '0;
`ifdef SPAWN_FOUR_EN
    spawn_val   = (lfsr_reg[6:4] == 3'b000) ? cell_t'(2) : cell_t'(1);
`else
    spawn_val   = cell_t'(1);
`endif
    for (logic [4:0] i = 5'd0; i < 5'd16; i = i + 5'd1) begin
      probe = lfsr_reg[3:0] + i[3:0];
      if (!spawn_hit && spawn_src[probe] == '0) begin
        spawn_hit = 1'b1;
        spawn_idx = probe;
      end
    end
    spawn_board = spawn_src;
    if (spawn_hit) begin
      spawn_board[spawn_idx] = spawn_val;
    end
  end

  assign lfsr_next = {lfsr_reg[14:0],
                      lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  // Spawn LFSR free-runs every clock.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Command FSM: owns the board, the shadow board and every status output.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg  <= ST_IDLE;
      line_reg   <= '0;
      dir_reg    <= '0;
      grid_reg   <= '0;
      shadow_reg <= '0;
      ready_reg  <= 1'b1;
      done_reg   <= 1'b0;
      moved_reg  <= 1'b0;
      over_reg   <= 1'b0;
      win_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          over_reg <= board_over;
          win_reg  <= win_reg | (|cell_win);
          if (iNew_game) begin
            grid_reg  <= '0;
            over_reg  <= 1'b0;
            win_reg   <= 1'b0;
            moved_reg <= 1'b0;
            ready_reg <= 1'b0;
            state_reg <= ST_INIT0;
          end else if (iWr_en) begin
            grid_reg[iWr_idx] <= iWr_val;
          end else if (iMove_valid) begin
            shadow_reg <= grid_reg;
            dir_reg    <= iMove_dir;
            line_reg   <= '0;
            ready_reg  <= 1'b0;
            state_reg  <= ST_SLIDE;
          end
        end
        ST_INIT0: begin
          grid_reg  <= spawn_board;
          state_reg <= ST_INIT1;
        end
        ST_INIT1: begin
          grid_reg  <= spawn_board;
          state_reg <= ST_CHECK;
        end
        ST_SLIDE: begin
          shadow_reg <= slide_board;
          line_reg   <= line_reg + 2'd1;
          if (line_reg == 2'd3) begin
            state_reg <= ST_SPAWN;
          end
        end
        ST_SPAWN: begin
          moved_reg <= board_moved;
          if (board_moved) begin
            grid_reg <= spawn_board;
          end
          state_reg <= ST_CHECK;
        end
        ST_CHECK: begin
          over_reg  <= board_over;
          win_reg   <= win_reg | (|cell_win);
          done_reg  <= 1'b1;
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign oGrid      = grid_reg;
  assign oReady     = ready_reg;
  assign oDone      = done_reg;
  assign oMoved     = moved_reg;
  assign oGame_over = over_reg;
  assign oWin       = win_reg;

endmodule
